// File: rtl/count_bcd_pkg.sv
// count_bcd_pkg: definitions shared by the count_bcd_display block.
//   state_t          FSM states of the display stage
//   SEG_0..SEG_9     active-low seven-segment codes (bit0=a .. bit6=g, bit7=dp)
//   SEG_BLANK        all segments off
//   NUM_DIGITS       number of decimal digits / displays
//   MAX_IN_WIDTH     widest binary input that still fits in NUM_DIGITS digits
package count_bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    LOAD
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  localparam int unsigned NUM_DIGITS   = 6;
  localparam int unsigned MAX_IN_WIDTH = 19;
  localparam int unsigned BCD_W        = 4 * NUM_DIGITS;
  // Wide enough to hold MAX_IN_WIDTH as an iteration count.
  localparam int unsigned CNT_W        = $clog2(MAX_IN_WIDTH + 1);

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode: one BCD digit to an active-low seven-segment pattern.
//   i_bcd  in   4  BCD digit
//   o_seg  out  8  segments, bit0=a .. bit6=g, bit7=dp (dp always off);
//                  codes above 9 decode to blank
module seg7_decode
  import count_bcd_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/count_bcd_display.sv
// count_bcd_display: captures a binary counter value on a valid/ready
// handshake, converts it to decimal with a sequential shift-add-3 engine
// (one bit per cycle) and drives six active-low seven-segment displays.
//   clk          in   1         system clock
//   reset_n      in   1         asynchronous, active-low reset
//   in_value     in   IN_WIDTH  unsigned value to display
//   in_valid     in   1         in_value valid this cycle
//   in_ready     out  1         idle, a value can be accepted
//   update_done  out  1         one-cycle pulse when the displays change
//   hex0..hex5   out  8 each    digit 0 (LSD) .. digit 5, active-low
// Build option: define COUNT_BCD_DISPLAY_BLANK_EN for leading-zero blanking
// of hex1..hex5 (hex0 always shows its digit).
module count_bcd_display
  import count_bcd_pkg::*;
#(
  parameter int unsigned IN_WIDTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [IN_WIDTH-1:0] in_value,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                update_done,
  output logic [7:0]          hex0,
  output logic [7:0]          hex1,
  output logic [7:0]          hex2,
  output logic [7:0]          hex3,
  output logic [7:0]          hex4,
  output logic [7:0]          hex5
);

  if ((IN_WIDTH == 0) || (IN_WIDTH > MAX_IN_WIDTH)) begin : g_bad_width
    $error("count_bcd_display: IN_WIDTH must be in 1..19");
  end

  state_t              r_state;
  state_t              w_state_next;
  logic [IN_WIDTH-1:0] r_shift;
  logic [BCD_W-1:0]    r_bcd;
  logic [CNT_W-1:0]    r_iter;
  logic [BCD_W-1:0]    r_digits;
  logic                r_update_done;

  logic                w_accept;
  logic [BCD_W-1:0]    w_bcd_adj;
  logic [BCD_W-1:0]    w_bcd_next;
  logic [IN_WIDTH-1:0] w_shift_next;
  logic [7:0]          w_seg [NUM_DIGITS];
  logic [7:0]          w_hex [NUM_DIGITS];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = CONVERT;
        end
      end
      CONVERT: begin
        // r_iter counts down from IN_WIDTH; the iteration done with r_iter==1
        // is the last one.
        if (r_iter == CNT_W'(1)) begin
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  assign w_accept    = in_valid && in_ready;
  assign update_done = r_update_done;

  // ------------------------------------------------- shift-add-3 datapath
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) begin
        w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  // {bcd, shift} shifted left as one long register.
  assign w_bcd_next   = {w_bcd_adj[BCD_W-2:0], r_shift[IN_WIDTH-1]};
  assign w_shift_next = r_shift << 1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift       <= '0;
      r_bcd         <= '0;
      r_iter        <= '0;
      r_digits      <= '0;
      r_update_done <= 1'b0;
    end else begin
      r_update_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shift <= in_value;
            r_bcd   <= '0;
            r_iter  <= CNT_W'(IN_WIDTH);
          end
        end
        CONVERT: begin
          r_bcd   <= w_bcd_next;
          r_shift <= w_shift_next;
          r_iter  <= r_iter - CNT_W'(1);
        end
        LOAD: begin
          r_digits      <= r_bcd;
          r_update_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------- digit decode
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    seg7_decode u_seg7_decode (
      .i_bcd (r_digits[4*k +: 4]),
      .o_seg (w_seg[k])
    );
  end

`ifdef COUNT_BCD_DISPLAY_BLANK_EN
  // Scan from the top digit down; a digit blanks while it and everything
  // above it is zero. hex0 is never blanked.
  always_comb begin
    logic v_zero_above;
    w_hex        = w_seg;
    v_zero_above = 1'b1;
    for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
      v_zero_above = v_zero_above && (r_digits[4*k +: 4] == 4'd0);
      if (v_zero_above) begin
        w_hex[k] = SEG_BLANK;
      end
    end
  end
`else
  assign w_hex = w_seg;
`endif

  assign hex0 = w_hex[0];
  assign hex1 = w_hex[1];
  assign hex2 = w_hex[2];
  assign hex3 = w_hex[3];
  assign hex4 = w_hex[4];
  assign hex5 = w_hex[5];

endmodule
